double_port_mem_fifo: RTL and testbench

DOUBLE_PORT_MEM_FIFO -- requirements
Module: double_port_mem_fifo

---
 rtl/double_port_mem_fifo.sv | 172 +++++++++++++++++
 tb/tb_double_port_mem_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/double_port_mem_fifo.sv
// FIFO storing words in a synchronous-read dual-port RAM, with a registered
// output stage refilled by an EMPTY/FETCH/VALID fetch state machine.

module double_port_mem_wrapper #(
    parameter int SIZE    = 16,
    parameter int DATAW   = 32,
    parameter bit OUT_REG = 1'b0,
    parameter int AW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk_i,
    input  logic             wren_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [DATAW-1:0] wdata_i,
    input  logic             rden_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [DATAW-1:0] rdata_o
);
    logic [DATAW-1:0] mem_q [SIZE];
    logic [DATAW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (wren_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data only changes when a read is issued, so it holds between reads.
    always_ff @(posedge clk_i) begin
        if (rden_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    generate
        if (OUT_REG) begin : g_outReg
            logic [DATAW-1:0] rdataOut_q;
            always_ff @(posedge clk_i) begin
                rdataOut_q <= rdata_q;
            end
            assign rdata_o = rdataOut_q;
        end else begin : g_noOutReg
            assign rdata_o = rdata_q;
        end
    endgenerate
endmodule

module double_port_mem_fifo #(
    parameter int DATAW = 32,
    parameter int DEPTH = 16,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_valid_i,
    input  logic [DATAW-1:0] push_data_i,
    output logic             push_ready_o,
    output logic             pop_valid_o,
    output logic [DATAW-1:0] pop_data_o,
    input  logic             pop_ready_i,
    output logic [CNTW-1:0]  count_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        FETCH,
        VALID
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [DATAW-1:0] popData_q;
    logic             popValid_q;
    logic [DATAW-1:0] memRdata;
    logic [CNTW-1:0]  memCount;
    logic             pushFire, popFire, hasUnread, rdIssue;

    assign push_ready_o = (count_q < CNTW'(DEPTH)) & ~flush_i;
    assign pushFire     = push_valid_i & push_ready_o;
    assign popFire      = popValid_q & pop_ready_i & ~flush_i;

    // Words still sitting unread in the RAM: everything counted except the
    // one occupying the output stage or travelling through the read port.
    assign memCount  = count_q - {{(CNTW-1){1'b0}}, (state_q != EMPTY)};
    assign hasUnread = (memCount != '0);
    assign rdIssue   = ~flush_i & hasUnread &
                       ((state_q == EMPTY) | ((state_q == VALID) & popFire));

    double_port_mem_wrapper #(
        .SIZE    (DEPTH),
        .DATAW   (DATAW),
        .OUT_REG (1'b0)
    ) u_mem (
        .clk_i   (clk_i),
        .wren_i  (pushFire),
        .waddr_i (wrPtr_q),
        .wdata_i (push_data_i),
        .rden_i  (rdIssue),
        .raddr_i (rdPtr_q),
        .rdata_o (memRdata)
    );

    always_comb begin
        wrPtr_d = wrPtr_q + AW'(pushFire);
        rdPtr_d = rdPtr_q + AW'(rdIssue);
        count_d = count_q;
        if (pushFire && !popFire) begin
            count_d = count_q + 1'b1;
        end else if (popFire && !pushFire) begin
            count_d = count_q - 1'b1;
        end
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // A flush abandons any read in flight by returning straight to EMPTY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            popValid_q <= 1'b0;
            popData_q  <= '0;
        end else if (flush_i) begin
            state_q    <= EMPTY;
            popValid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (hasUnread) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    state_q    <= VALID;
                    popValid_q <= 1'b1;
                    popData_q  <= memRdata;
                end
                VALID: begin
                    if (popFire) begin
                        popValid_q <= 1'b0;
                        state_q    <= hasUnread ? FETCH : EMPTY;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    popValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pop_valid_o = popValid_q;
    assign pop_data_o  = popData_q;
    assign count_o     = count_q;
endmodule

// File: tb/tb_double_port_mem_fifo.sv
// Self-checking bench for double_port_mem_fifo: directed vector table,
// hand-written corner sequences and a queue-based random scoreboard.

module tb_double_port_mem_fifo;
    localparam int DATAW = 32;
    localparam int DEPTH = 16;
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int NVEC  = 15;
    localparam int NRAND = 40;

    logic             clk = 1'b0;
    logic             rstN;
    logic             flush;
    logic             pushValid;
    logic [DATAW-1:0] pushData;
    logic             pushReady;
    logic             popValid;
    logic [DATAW-1:0] popData;
    logic             popReady;
    logic [CNTW-1:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        pv;
        logic [31:0] pd;
        logic        pr;
        logic        fl;
        int          expCount;
        logic        expReady;
        logic        expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t        vecs [NVEC];
    logic [31:0] modelQ [$];
    int          sent, received, nextWord, cycles;
    logic        willPush, willPop, stalled;
    logic [31:0] stalledData, randData;
    logic        randPv, randPr;

    double_port_mem_fifo #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .flush_i      (flush),
        .push_valid_i (pushValid),
        .push_data_i  (pushData),
        .push_ready_o (pushReady),
        .pop_valid_o  (popValid),
        .pop_data_o   (popData),
        .pop_ready_i  (popReady),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [31:0] pd,
                                 input logic pr, input logic fl);
        pushValid = pv;
        pushData  = pd;
        popReady  = pr;
        flush     = fl;
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mkVec(input logic pv, input logic [31:0] pd, input logic pr,
                                   input logic fl, input int ec, input logic er,
                                   input logic ev, input logic [31:0] ed);
        vec_t v;
        v.pv = pv; v.pd = pd; v.pr = pr; v.fl = fl;
        v.expCount = ec; v.expReady = er; v.expValid = ev; v.expData = ed;
        return v;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Push at edge N is read at edge N+1 and valid after edge N+2.
        vecs[0]  = mkVec(0, 32'h00, 0, 0, 0, 1, 0, 32'h00);
        vecs[1]  = mkVec(1, 32'hA5, 0, 0, 1, 1, 0, 32'h00);
        vecs[2]  = mkVec(0, 32'h00, 0, 0, 1, 1, 0, 32'h00);
        vecs[3]  = mkVec(0, 32'h00, 0, 0, 1, 1, 1, 32'hA5);
        vecs[4]  = mkVec(0, 32'h00, 1, 0, 0, 1, 0, 32'h00);
        vecs[5]  = mkVec(1, 32'h11, 0, 0, 1, 1, 0, 32'h00);
        vecs[6]  = mkVec(1, 32'h22, 0, 0, 2, 1, 0, 32'h00);
        vecs[7]  = mkVec(0, 32'h00, 0, 0, 2, 1, 1, 32'h11);
        vecs[8]  = mkVec(0, 32'h00, 1, 0, 1, 1, 0, 32'h00);
        vecs[9]  = mkVec(0, 32'h00, 0, 0, 1, 1, 1, 32'h22);
        vecs[10] = mkVec(1, 32'h33, 1, 0, 1, 1, 0, 32'h00);
        vecs[11] = mkVec(0, 32'h00, 0, 0, 1, 1, 0, 32'h00);
        vecs[12] = mkVec(0, 32'h00, 0, 0, 1, 1, 1, 32'h33);
        vecs[13] = mkVec(1, 32'h44, 1, 1, 0, 0, 0, 32'h00);
        vecs[14] = mkVec(0, 32'h00, 0, 0, 0, 1, 0, 32'h00);

        applyStimulus(0, 0, 0, 0);
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1;
        checkOutput("resetCount", 32'(count), 0);
        checkOutput("resetPopValid", 32'(popValid), 0);
        checkOutput("resetPopData", popData, 0);
        #21 rstN = 1'b1;
        @(negedge clk);
        checkOutput("releasePushReady", 32'(pushReady), 1);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].pv, vecs[i].pd, vecs[i].pr, vecs[i].fl);
            stepClock();
            checkOutput($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d.pushReady", i), 32'(pushReady), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d.popValid", i), 32'(popValid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d.popData", i), popData, vecs[i].expData);
            end
        end

        // Fill to capacity with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 32'(i), 0, 0);
            stepClock();
        end
        checkOutput("fullCount", 32'(count), DEPTH);
        checkOutput("fullPushReady", 32'(pushReady), 0);
        checkOutput("fullPopValid", 32'(popValid), 1);
        checkOutput("fullPopData", popData, 0);

        // Push and pop together while full: only the pop takes effect.
        applyStimulus(1, 32'hDEAD, 1, 0);
        #1;
        checkOutput("fullPopPushReady", 32'(pushReady), 0);
        stepClock();
        checkOutput("fullPopCount", 32'(count), DEPTH - 1);
        checkOutput("fullPopReadyNext", 32'(pushReady), 1);

        applyStimulus(0, 0, 1, 0);
        nextWord = 1;
        cycles = 0;
        while (nextWord < DEPTH && cycles < 200) begin
            if (popValid) begin
                checkOutput($sformatf("drain%0d", nextWord), popData, 32'(nextWord));
                nextWord++;
            end
            stepClock();
            cycles++;
        end
        checkOutput("drainWords", 32'(nextWord), DEPTH);
        checkOutput("drainCount", 32'(count), 0);

        // Flush with five words held and a read in flight.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, 32'h100 + 32'(i), 0, 0);
            stepClock();
        end
        checkOutput("preFlushData", popData, 32'h101);
        applyStimulus(0, 0, 1, 0);
        stepClock();
        checkOutput("preFlushCount", 32'(count), 5);
        checkOutput("preFlushInFlight", 32'(popValid), 0);
        applyStimulus(0, 0, 0, 1);
        stepClock();
        checkOutput("flushCount", 32'(count), 0);
        checkOutput("flushPopValid", 32'(popValid), 0);
        applyStimulus(1, 32'h3C, 0, 0);
        #1;
        checkOutput("postFlushReady", 32'(pushReady), 1);
        stepClock();
        applyStimulus(0, 0, 0, 0);
        stepClock();
        checkOutput("postFlushEarly", 32'(popValid), 0);
        stepClock();
        checkOutput("postFlushValid", 32'(popValid), 1);
        checkOutput("postFlushData", popData, 32'h3C);
        applyStimulus(0, 0, 1, 0);
        stepClock();
        checkOutput("postFlushCount", 32'(count), 0);

        // Asynchronous reset with seven words held.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 32'h200 + 32'(i), 0, 0);
            stepClock();
        end
        checkOutput("preResetCount", 32'(count), 7);
        applyStimulus(0, 0, 0, 0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midResetCount", 32'(count), 0);
        checkOutput("midResetPopValid", 32'(popValid), 0);
        checkOutput("midResetPopData", popData, 0);
        @(posedge clk);
        #3 rstN = 1'b1;
        @(negedge clk);
        checkOutput("afterResetReady", 32'(pushReady), 1);
        checkOutput("afterResetCount", 32'(count), 0);
        applyStimulus(1, 32'h77, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0);
        stepClock();
        checkOutput("afterResetEarly", 32'(popValid), 0);
        stepClock();
        checkOutput("afterResetValid", 32'(popValid), 1);
        checkOutput("afterResetData", popData, 32'h77);
        applyStimulus(0, 0, 1, 0);
        stepClock();
        checkOutput("afterResetDrained", 32'(count), 0);

        // Random traffic with backpressure, scored against a queue.
        sent = 0;
        received = 0;
        cycles = 0;
        while (received < NRAND && cycles < 3000) begin
            randPv   = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            randData = $urandom;
            randPr   = ($urandom_range(0, 2) != 0);
            applyStimulus(randPv, randData, randPr, 0);
            #1;
            checkOutput("randPushReady", 32'(pushReady), 32'(modelQ.size() < DEPTH));
            willPush = randPv && (modelQ.size() < DEPTH);
            willPop  = popValid && randPr;
            stalled  = popValid && !randPr;
            stalledData = popData;
            if (willPop) begin
                if (modelQ.size() == 0) begin
                    checkOutput("randPopWhenEmpty", 32'(popValid), 0);
                    willPop = 1'b0;
                end else begin
                    checkOutput($sformatf("randPop%0d", received), popData, modelQ[0]);
                end
            end
            @(negedge clk);
            if (willPush) begin
                modelQ.push_back(randData);
                sent++;
            end
            if (willPop) begin
                void'(modelQ.pop_front());
                received++;
            end
            checkOutput("randCount", 32'(count), 32'(modelQ.size()));
            if (stalled) begin
                checkOutput("stallValid", 32'(popValid), 1);
                checkOutput("stallData", popData, stalledData);
            end
            cycles++;
        end
        checkOutput("randReceived", 32'(received), NRAND);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
